gpio_ctrl: RTL and testbench

Wishbone-slave GPIO controller that owns the 8-bit pin interface (input, output, direction) observed by the simulation GPIO listener. It synchronises pin inputs, detects selectable edges per pin, latches them into a sticky interrupt status register, and exposes output, direction and interrupt configuration through a single-cycle-acknowledge register bus. It sits between the system bus and the board pins, one instance per GPIO bank.

---
 rtl/gpio_ctrl_pkg.sv | 22 ++
 rtl/gpio_ctrl_if.sv | 23 ++
 rtl/gpio_sync_edge.sv | 50 +++++
 rtl/gpio_ctrl.sv | 104 ++++++++++
 tb/tb_gpio_ctrl.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_ctrl_pkg.sv
// gpio_ctrl shared definitions: register indices and reset constants.
// Imported by the GPIO controller, its sub-module and the bus interface users.
package gpio_ctrl_pkg;

    typedef enum logic [2:0] {
        GPIO_REG_DATA_IN  = 3'd0,
        GPIO_REG_DATA_OUT = 3'd1,
        GPIO_REG_DIR      = 3'd2,
        GPIO_REG_OUT_SET  = 3'd3,
        GPIO_REG_OUT_CLR  = 3'd4,
        GPIO_REG_IRQ_EN   = 3'd5,
        GPIO_REG_IRQ_STAT = 3'd6,
        GPIO_REG_EDGE_SEL = 3'd7
    } gpio_reg_t;

    // EDGE_SEL resets to all-ones: every pin watches rising edges.
    localparam logic [31:0] GPIO_EDGE_SEL_RST = 32'hFFFF_FFFF;

    // Warm-up counter value at which edge detection is unmasked.
    localparam logic [1:0] GPIO_WARM_DONE = 2'd3;

endpackage

// File: rtl/gpio_ctrl_if.sv
// Register bus (Wishbone-style, single-cycle acknowledge) for gpio_ctrl.
// Ports: CYC_I/STB_I/WE_I/ADR_I/DAT_I from master, DAT_O/ACK_O from slave.
interface gpio_ctrl_if;

    logic        CYC_I;
    logic        STB_I;
    logic        WE_I;
    logic [2:0]  ADR_I;
    logic [31:0] DAT_I;
    logic [31:0] DAT_O;
    logic        ACK_O;

    modport master (
        output CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        input  DAT_O, ACK_O
    );

    modport slave (
        input  CYC_I, STB_I, WE_I, ADR_I, DAT_I,
        output DAT_O, ACK_O
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// Pin input conditioning: two-flop synchroniser, previous-level register,
// warm-up mask and per-pin edge select.
// Ports: clk, rst (sync, active-high), pin_in (async pins), dir (1 = output),
//        edge_sel (1 = rising), sync (synchronised level), edge_pulse (1-cycle).
module gpio_sync_edge
    import gpio_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pin_in,
    input  logic [WIDTH-1:0] dir,
    input  logic [WIDTH-1:0] edge_sel,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] edge_pulse
);

    logic [WIDTH-1:0] meta;
    logic [WIDTH-1:0] prev;
    logic [1:0]       warm;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            sync <= '0;
            prev <= '0;
            warm <= '0;
        end else begin
            meta <= pin_in;
            sync <= meta;
            prev <= sync;
            if (warm != GPIO_WARM_DONE) begin
                warm <= warm + 2'd1;
            end
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

    // Masked until the pipeline has refilled after reset, so levels already
    // present at reset release do not look like edges.
    assign edge_pulse = (warm == GPIO_WARM_DONE)
                      ? (~dir & ((edge_sel & rise) | (~edge_sel & fall)))
                      : '0;

endmodule

// File: rtl/gpio_ctrl.sv
// GPIO bank controller: register file, bus decode, ack, sticky edge status, IRQ.
// Ports: CLK_I, RST_I (sync, active-high), bus (slave register bus),
//        PIN_IN_I (async pins), PIN_OUT_O, PIN_DIR_O (1 = output), IRQ_O (level).
module gpio_ctrl
    import gpio_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             CLK_I,
    input  logic             RST_I,
    gpio_ctrl_if.slave       bus,
    input  logic [WIDTH-1:0] PIN_IN_I,
    output logic [WIDTH-1:0] PIN_OUT_O,
    output logic [WIDTH-1:0] PIN_DIR_O,
    output logic             IRQ_O
);

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irq_en;
    logic [WIDTH-1:0] irq_stat;
    logic [WIDTH-1:0] edge_sel;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] edge_pulse;
    logic [WIDTH-1:0] wdat;
    logic [WIDTH-1:0] stat_clr;
    logic [31:0]      rdata;
    logic             access;
    logic             wr;
    logic             rd;
    gpio_reg_t        reg_sel;
    logic             unused_dat;

    gpio_sync_edge #(
        .WIDTH (WIDTH)
    ) u_sync_edge (
        .clk        (CLK_I),
        .rst        (RST_I),
        .pin_in     (PIN_IN_I),
        .dir        (dir),
        .edge_sel   (edge_sel),
        .sync       (sync),
        .edge_pulse (edge_pulse)
    );

    // A held strobe is accepted every other cycle because ACK_O gates it.
    assign access  = bus.CYC_I & bus.STB_I & ~bus.ACK_O;
    assign wr      = access & bus.WE_I;
    assign rd      = access & ~bus.WE_I;
    assign reg_sel = gpio_reg_t'(bus.ADR_I);
    assign wdat    = bus.DAT_I[WIDTH-1:0];

    // Data bits above WIDTH are ignored on write.
    assign unused_dat = ^bus.DAT_I;

    assign stat_clr = (wr && reg_sel == GPIO_REG_IRQ_STAT) ? wdat : '0;

    always_comb begin
        rdata = '0;
        case (reg_sel)
            GPIO_REG_DATA_IN:  rdata[WIDTH-1:0] = sync;
            GPIO_REG_DATA_OUT: rdata[WIDTH-1:0] = data_out;
            GPIO_REG_DIR:      rdata[WIDTH-1:0] = dir;
            GPIO_REG_IRQ_EN:   rdata[WIDTH-1:0] = irq_en;
            GPIO_REG_IRQ_STAT: rdata[WIDTH-1:0] = irq_stat;
            GPIO_REG_EDGE_SEL: rdata[WIDTH-1:0] = edge_sel;
            default:           rdata = '0;
        endcase
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            data_out  <= '0;
            dir       <= '0;
            irq_en    <= '0;
            irq_stat  <= '0;
            edge_sel  <= GPIO_EDGE_SEL_RST[WIDTH-1:0];
            bus.ACK_O <= 1'b0;
            bus.DAT_O <= '0;
            IRQ_O     <= 1'b0;
        end else begin
            bus.ACK_O <= access;
            bus.DAT_O <= rd ? rdata : '0;
            // New edges override a same-cycle write-1-to-clear.
            irq_stat  <= (irq_stat & ~stat_clr) | edge_pulse;
            IRQ_O     <= |(irq_stat & irq_en);
            if (wr) begin
                case (reg_sel)
                    GPIO_REG_DATA_OUT: data_out <= wdat;
                    GPIO_REG_DIR:      dir      <= wdat;
                    GPIO_REG_OUT_SET:  data_out <= data_out | wdat;
                    GPIO_REG_OUT_CLR:  data_out <= data_out & ~wdat;
                    GPIO_REG_IRQ_EN:   irq_en   <= wdat;
                    GPIO_REG_EDGE_SEL: edge_sel <= wdat;
                    default:           ;
                endcase
            end
        end
    end

    assign PIN_OUT_O = data_out;
    assign PIN_DIR_O = dir;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl: directed scenarios plus randomized
// bus/pin traffic compared cycle by cycle against a behavioural model.
module tb_gpio_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] pin_in;
    wire  [7:0] pin_out;
    wire  [7:0] pin_dir;
    wire        irq;

    int checks   = 0;
    int failures = 0;

    gpio_ctrl_if bus ();

    gpio_ctrl #(
        .WIDTH (8)
    ) dut (
        .CLK_I     (clk),
        .RST_I     (rst),
        .bus       (bus.slave),
        .PIN_IN_I  (pin_in),
        .PIN_OUT_O (pin_out),
        .PIN_DIR_O (pin_dir),
        .IRQ_O     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model state.
    logic [7:0]  m_out, m_dir, m_en, m_stat, m_sel;
    logic        m_ack, m_irq;
    logic [31:0] m_dat;
    int          m_k;
    logic [7:0]  hist[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.CYC_I = 1'b0;
        bus.STB_I = 1'b0;
        bus.WE_I  = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_bus();
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b1;
        bus.ADR_I = a;
        bus.DAT_I = d;
        tick();
        idle_bus();
        tick();
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b0;
        bus.ADR_I = a;
        tick();
        d = bus.DAT_O;
        idle_bus();
        tick();
    endtask

    task automatic model_reset();
        m_out  = 8'h00;
        m_dir  = 8'h00;
        m_en   = 8'h00;
        m_stat = 8'h00;
        m_sel  = 8'hFF;
        m_ack  = 1'b0;
        m_irq  = 1'b0;
        m_dat  = 32'h0;
        m_k    = 0;
        hist   = '{8'h00, 8'h00, 8'h00, 8'h00};
    endtask

    // Advances the model across the coming clock edge from the inputs now
    // driven. Pins sampled at edge j are visible as the stable level two
    // edges later; an edge compares that level with the one before it.
    task automatic model_step();
        logic       acc;
        logic [7:0] lvl_new, lvl_old, edges, clr, rdv;
        if (rst) begin
            model_reset();
            return;
        end
        acc = bus.CYC_I && bus.STB_I && !m_ack;
        hist.push_back(pin_in);
        void'(hist.pop_front());
        m_k++;
        lvl_old = hist[0];
        lvl_new = hist[1];
        edges = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (m_k > 3 && !m_dir[i]) begin
                if (m_sel[i] && lvl_new[i] && !lvl_old[i]) edges[i] = 1'b1;
                if (!m_sel[i] && !lvl_new[i] && lvl_old[i]) edges[i] = 1'b1;
            end
        end
        case (bus.ADR_I)
            3'd0:    rdv = lvl_new;
            3'd1:    rdv = m_out;
            3'd2:    rdv = m_dir;
            3'd5:    rdv = m_en;
            3'd6:    rdv = m_stat;
            3'd7:    rdv = m_sel;
            default: rdv = 8'h00;
        endcase
        m_irq = (m_stat & m_en) != 8'h00;
        m_dat = (acc && !bus.WE_I) ? {24'h0, rdv} : 32'h0;
        clr = (acc && bus.WE_I && bus.ADR_I == 3'd6) ? bus.DAT_I[7:0] : 8'h00;
        m_stat = (m_stat & ~clr) | edges;
        if (acc && bus.WE_I) begin
            case (bus.ADR_I)
                3'd1:    m_out = bus.DAT_I[7:0];
                3'd2:    m_dir = bus.DAT_I[7:0];
                3'd3:    m_out = m_out | bus.DAT_I[7:0];
                3'd4:    m_out = m_out & ~bus.DAT_I[7:0];
                3'd5:    m_en  = bus.DAT_I[7:0];
                3'd7:    m_sel = bus.DAT_I[7:0];
                default: ;
            endcase
        end
        m_ack = acc;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        pin_in = 8'hFF;
        do_reset();
        repeat (10) tick();
        checks++; if (pin_out !== 8'h00) begin failures++; $display("FAIL reset_pin_out got=%h exp=00", pin_out); end
        checks++; if (pin_dir !== 8'h00) begin failures++; $display("FAIL reset_pin_dir got=%h exp=00", pin_dir); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
        checks++; if (bus.ACK_O !== 1'b0) begin failures++; $display("FAIL reset_ack got=%b exp=0", bus.ACK_O); end
        bus_read(3'd6, d);
        checks++; if (d !== 32'h00) begin failures++; $display("FAIL reset_irq_stat got=%h exp=0", d); end
        bus_read(3'd0, d);
        checks++; if (d !== 32'hFF) begin failures++; $display("FAIL reset_data_in got=%h exp=ff", d); end
        bus_read(3'd7, d);
        checks++; if (d !== 32'hFF) begin failures++; $display("FAIL reset_edge_sel got=%h exp=ff", d); end
        bus_read(3'd5, d);
        checks++; if (d !== 32'h00) begin failures++; $display("FAIL reset_irq_en got=%h exp=0", d); end
    endtask

    task automatic test_out_setclr();
        logic [31:0] d;
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b1;
        bus.ADR_I = 3'd1;
        bus.DAT_I = 32'hFFFF_FFA5;
        tick();
        checks++; if (bus.ACK_O !== 1'b1) begin failures++; $display("FAIL wr_ack_high got=%b exp=1", bus.ACK_O); end
        idle_bus();
        tick();
        checks++; if (bus.ACK_O !== 1'b0) begin failures++; $display("FAIL wr_ack_low got=%b exp=0", bus.ACK_O); end
        checks++; if (pin_out !== 8'hA5) begin failures++; $display("FAIL out_write got=%h exp=a5", pin_out); end
        bus_write(3'd3, 32'h0A);
        checks++; if (pin_out !== 8'hAF) begin failures++; $display("FAIL out_set got=%h exp=af", pin_out); end
        bus_write(3'd4, 32'h81);
        checks++; if (pin_out !== 8'h2E) begin failures++; $display("FAIL out_clr got=%h exp=2e", pin_out); end
        bus_read(3'd3, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rd_out_set got=%h exp=0", d); end
        bus_read(3'd4, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rd_out_clr got=%h exp=0", d); end
        bus_read(3'd1, d);
        checks++; if (d !== 32'h2E) begin failures++; $display("FAIL rd_data_out got=%h exp=2e", d); end
    endtask

    task automatic test_irq_timing();
        logic [31:0] d;
        pin_in = 8'h00;
        repeat (5) tick();
        bus_write(3'd6, 32'hFF);
        bus_write(3'd5, 32'h01);
        pin_in = 8'h01;
        tick();
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_n1 got=%b exp=0", irq); end
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b0;
        bus.ADR_I = 3'd6;
        tick();
        checks++; if (bus.DAT_O !== 32'h0) begin failures++; $display("FAIL stat_before_n2 got=%h exp=0", bus.DAT_O); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_n2 got=%b exp=0", irq); end
        idle_bus();
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_n3 got=%b exp=1", irq); end
        bus_read(3'd6, d);
        checks++; if (d !== 32'h01) begin failures++; $display("FAIL stat_set got=%h exp=1", d); end
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b1;
        bus.ADR_I = 3'd6;
        bus.DAT_I = 32'h01;
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_at_clr got=%b exp=1", irq); end
        idle_bus();
        tick();
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_clr got=%b exp=0", irq); end
        bus_read(3'd6, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL stat_cleared got=%h exp=0", d); end
    endtask

    task automatic test_edge_sel();
        logic [31:0] d;
        bus_write(3'd7, 32'hFE);
        pin_in = 8'h00;
        repeat (4) tick();
        bus_read(3'd6, d);
        checks++; if (d !== 32'h01) begin failures++; $display("FAIL fall_sets got=%h exp=1", d); end
        bus_write(3'd6, 32'hFF);
        pin_in = 8'h01;
        repeat (4) tick();
        bus_read(3'd6, d);
        checks++; if (d !== 32'h00) begin failures++; $display("FAIL rise_ignored got=%h exp=0", d); end
        bus_write(3'd2, 32'h01);
        checks++; if (pin_dir !== 8'h01) begin failures++; $display("FAIL dir_out got=%h exp=1", pin_dir); end
        pin_in = 8'h00;
        repeat (4) tick();
        pin_in = 8'h01;
        repeat (4) tick();
        bus_read(3'd6, d);
        checks++; if (d !== 32'h00) begin failures++; $display("FAIL dir_masks got=%h exp=0", d); end
        bus_write(3'd2, 32'h00);
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        bus_write(3'd7, 32'hFF);
        pin_in = 8'h00;
        repeat (4) tick();
        bus_write(3'd6, 32'hFF);
        pin_in = 8'h08;
        tick();
        tick();
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b1;
        bus.ADR_I = 3'd6;
        bus.DAT_I = 32'h08;
        tick();
        idle_bus();
        tick();
        bus_read(3'd6, d);
        checks++; if (d !== 32'h08) begin failures++; $display("FAIL set_wins got=%h exp=8", d); end
        bus_write(3'd6, 32'h08);
        bus_read(3'd6, d);
        checks++; if (d !== 32'h00) begin failures++; $display("FAIL w1c_bit3 got=%h exp=0", d); end
    endtask

    task automatic test_held_strobe();
        logic [5:0] seen;
        logic [5:0] exp_pat;
        exp_pat = 6'b101010;
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b0;
        bus.ADR_I = 3'd0;
        for (int i = 0; i < 6; i++) begin
            seen[i] = bus.ACK_O;
            tick();
        end
        idle_bus();
        tick();
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (seen[i] !== exp_pat[i]) begin
                failures++;
                $display("FAIL held_ack[%0d] got=%b exp=%b", i, seen[i], exp_pat[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        bus.CYC_I = 1'b1;
        bus.STB_I = 1'b1;
        bus.WE_I  = 1'b1;
        bus.ADR_I = 3'd2;
        bus.DAT_I = 32'hFF;
        rst = 1'b1;
        tick();
        checks++; if (bus.ACK_O !== 1'b0) begin failures++; $display("FAIL rst_mid_ack got=%b exp=0", bus.ACK_O); end
        checks++; if (pin_dir !== 8'h00) begin failures++; $display("FAIL rst_mid_dir got=%h exp=0", pin_dir); end
        idle_bus();
        rst = 1'b0;
        repeat (4) tick();
        bus_read(3'd2, d);
        checks++; if (d !== 32'h0) begin failures++; $display("FAIL rst_mid_dir_rd got=%h exp=0", d); end
    endtask

    task automatic test_random();
        rst = 1'b1;
        idle_bus();
        for (int i = 0; i < 3; i++) begin
            model_step();
            tick();
        end
        rst = 1'b0;
        for (int i = 0; i < 600; i++) begin
            rst = (i == 300 || i == 301);
            if ($urandom_range(2) == 0) pin_in = 8'($urandom);
            bus.CYC_I = ($urandom_range(3) != 0);
            bus.STB_I = ($urandom_range(3) != 0);
            bus.WE_I  = $urandom_range(1) == 1;
            bus.ADR_I = 3'($urandom_range(7));
            bus.DAT_I = $urandom;
            model_step();
            tick();
            checks++; if (pin_out !== m_out) begin failures++; $display("FAIL rnd_out cyc=%0d got=%h exp=%h", i, pin_out, m_out); end
            checks++; if (pin_dir !== m_dir) begin failures++; $display("FAIL rnd_dir cyc=%0d got=%h exp=%h", i, pin_dir, m_dir); end
            checks++; if (irq !== m_irq) begin failures++; $display("FAIL rnd_irq cyc=%0d got=%b exp=%b", i, irq, m_irq); end
            checks++; if (bus.ACK_O !== m_ack) begin failures++; $display("FAIL rnd_ack cyc=%0d got=%b exp=%b", i, bus.ACK_O, m_ack); end
            checks++; if (bus.DAT_O !== m_dat) begin failures++; $display("FAIL rnd_dat cyc=%0d got=%h exp=%h", i, bus.DAT_O, m_dat); end
        end
        rst = 1'b0;
        idle_bus();
    endtask

    initial begin
        rst       = 1'b1;
        pin_in    = 8'hFF;
        bus.ADR_I = 3'd0;
        bus.DAT_I = 32'h0;
        idle_bus();
        model_reset();
        test_reset();
        test_out_setclr();
        test_irq_timing();
        test_edge_sel();
        test_w1c_race();
        test_held_strobe();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
